// File: rtl/ifft64_frame_sequencer.sv
// Frame-level controller for the 64-point SDF IFFT: input handshake and frame spacing,
// per-frame twiddle-stage activation pulses, and output valid/last framing.
module ifft64_frame_sequencer #(
  parameter int NFFT    = 64,
  parameter int T1      = 48,
  parameter int T2      = 60,
  parameter int T3      = 63,
  parameter int OUT_LAT = 66
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       clr_err,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] tw_active,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       err_underflow,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(NFFT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       in_cnt;
  logic [CW-1:0]       out_cnt;
  logic [OUT_LAT-1:0]  dl;
  logic [OUT_LAT-1:0]  ev;
  logic                start;

  // Handshake: a sample transfers on any rising edge where in_valid && in_ready.
  // in_ready is low only in the single GAP cycle and while flush is asserted.
  assign in_ready  = (state != GAP) && !flush;
  assign start     = (state == IDLE) && in_valid && in_ready;
  assign busy      = (state != IDLE) || (|dl) || out_valid;
  assign state_dbg = state;

  // ev[i] is high when a frame's first sample was accepted i edges ago;
  // registering a tap at ev[T-1] makes the output visible exactly T cycles later.
  assign ev = {dl[OUT_LAT-2:0], start};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      in_cnt        <= '0;
      out_cnt       <= '0;
      dl            <= '0;
      tw_active     <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      err_underflow <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      in_cnt        <= '0;
      out_cnt       <= '0;
      dl            <= '0;
      tw_active     <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      dl        <= ev;
      tw_active <= {ev[T3-1], ev[T2-1], ev[T1-1]};

      case (state)
        IDLE: begin
          if (start) begin
            state  <= FRAME;
            in_cnt <= CW'(1);
          end
        end
        FRAME: begin
          in_cnt <= in_cnt + CW'(1);
          if (in_cnt == CW'(NFFT - 1)) state <= GAP;
        end
        GAP: begin
          state  <= IDLE;
          in_cnt <= '0;
        end
        default: state <= IDLE;
      endcase

      // Output window: the OUT_LAT tap (re)loads the counter; windows never collide.
      if (ev[OUT_LAT-1]) begin
        out_valid <= 1'b1;
        out_cnt   <= '0;
        out_last  <= 1'b0;
      end else if (out_valid) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_cnt   <= '0;
        end else begin
          out_cnt  <= out_cnt + CW'(1);
          out_last <= (out_cnt == CW'(NFFT - 2));
        end
      end

      // The pipeline is free-running, so a missing sample only raises the sticky flag.
      if (state == FRAME && !in_valid) err_underflow <= 1'b1;
      else if (clr_err)                err_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifft64_frame_sequencer.sv
// Directed bench for ifft64_frame_sequencer: per-cycle expectations derived from frame
// start times and the fixed offsets 48/60/63 (twiddles) and 66..129 (output window).
module tb_ifft64_frame_sequencer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       clr_err;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] tw_active;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       err_underflow;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int starts[$];

  ifft64_frame_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .clr_err       (clr_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .tw_active     (tw_active),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .busy          (busy),
    .err_underflow (err_underflow),
    .state_dbg     (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // Expected outputs at cycle n (value seen just before edge n) from the frame start list.
  task automatic check_cycle(input int n, input bit exp_err, input bit fl);
    int d;
    logic [2:0] etw;
    logic [1:0] est;
    logic eov, eol, ebusy, erdy;
    etw = 3'b000; est = 2'd0; eov = 1'b0; eol = 1'b0; ebusy = 1'b0; erdy = 1'b1;
    foreach (starts[i]) begin
      d = n - starts[i];
      if (d == 48) etw[0] = 1'b1;
      if (d == 60) etw[1] = 1'b1;
      if (d == 63) etw[2] = 1'b1;
      if (d >= 66 && d <= 129) eov = 1'b1;
      if (d == 129) eol = 1'b1;
      if (d >= 1 && d <= 129) ebusy = 1'b1;
      if (d >= 1 && d <= 63) est = 2'd1;
      if (d == 64) begin est = 2'd2; erdy = 1'b0; end
    end
    if (fl) erdy = 1'b0;
    chk("in_ready",      n, {7'd0, in_ready},      {7'd0, erdy});
    chk("tw_active",     n, {5'd0, tw_active},     {5'd0, etw});
    chk("out_valid",     n, {7'd0, out_valid},     {7'd0, eov});
    chk("out_last",      n, {7'd0, out_last},      {7'd0, eol});
    chk("busy",          n, {7'd0, busy},          {7'd0, ebusy});
    chk("err_underflow", n, {7'd0, err_underflow}, {7'd0, exp_err});
    chk("state",         n, {6'd0, state_dbg},     {6'd0, est});
  endtask

  // driver task: apply inputs for edge n, check cycle n, advance to the next negedge
  task automatic step(input int n, input bit v, input bit f, input bit c, input bit exp_err);
    in_valid = v;
    flush    = f;
    clr_err  = c;
    #1;
    check_cycle(n, exp_err, f);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input int tag_n);
    chk("rst_in_ready",  tag_n, {7'd0, in_ready},      8'd1);
    chk("rst_tw_active", tag_n, {5'd0, tw_active},     8'd0);
    chk("rst_out_valid", tag_n, {7'd0, out_valid},     8'd0);
    chk("rst_out_last",  tag_n, {7'd0, out_last},      8'd0);
    chk("rst_busy",      tag_n, {7'd0, busy},          8'd0);
    chk("rst_err",       tag_n, {7'd0, err_underflow}, 8'd0);
    chk("rst_state",     tag_n, {6'd0, state_dbg},     8'd0);
  endtask

  task automatic do_reset(input int tag_n);
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    clr_err  = 1'b0;
    #1;
    check_reset_values(tag_n);
    repeat (2) @(negedge clk);
    check_reset_values(tag_n);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; clr_err = 1'b0; in_valid = 1'b0;

    // power-on reset
    do_reset(-1);

    // single frame, in_valid high for 64 cycles
    starts.delete(); starts.push_back(0);
    for (int n = 0; n <= 140; n++) step(n, n < 64, 1'b0, 1'b0, 1'b0);

    // continuous in_valid: second frame at 65, pulses 113/125/128, window 131..194
    do_reset(1000);
    starts.delete(); starts.push_back(0); starts.push_back(65);
    for (int n = 0; n <= 200; n++) step(n, n < 129, 1'b0, 1'b0, 1'b0);

    // underflow at cycle 20, clr_err at 200
    do_reset(2000);
    starts.delete(); starts.push_back(0);
    for (int n = 0; n <= 205; n++)
      step(n, (n < 64) && (n != 20), 1'b0, n == 200, (n >= 21) && (n <= 200));

    // flush at 55 with input still streaming; fresh frame from 57
    do_reset(3000);
    starts.delete(); starts.push_back(0);
    for (int n = 0; n <= 200; n++) begin
      if (n == 56) begin starts.delete(); starts.push_back(57); end
      step(n, (n != 56) && (n < 121), n == 55, 1'b0, 1'b0);
    end

    // asynchronous reset during the output window, then a fresh frame
    do_reset(4000);
    starts.delete(); starts.push_back(0);
    for (int n = 0; n < 70; n++) step(n, n < 64, 1'b0, 1'b0, 1'b0);
    do_reset(70);
    starts.delete(); starts.push_back(0);
    for (int n = 0; n <= 70; n++) step(n, n < 64, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
